hazard_interlock_unit: RTL and testbench

// - ID-stage interlock; the stall side of the EXE-stage forwarding logic.
//   It covers the hazards that forwarding cannot resolve.
// - Keeps a scoreboard of registers that are waiting on load data.
// - Stalls IF/ID and inserts a bubble into ID/EXE while a consumer waits on a pending load.
// - Freezes the whole pipe while memory is busy, and flushes the wrong path on a taken branch.

---
 rtl/hazard_interlock_unit.sv | 125 ++++++++++++
 tb/tb_hazard_interlock_unit.sv | 251 +++++++++++++++++++++++++
 2 files changed

// File: rtl/hazard_interlock_unit.sv
// ID-stage interlock: load scoreboard, load-use stall/bubble, memory freeze and branch flush.
// Optional HAZ_PERF_CNT_EN builds stall/flush performance counters (ports tied to 0 otherwise).
//
// state | meaning
// RUN   | pipe flowing, no interlock active
// HAZ   | ID consumer waiting on a pending load
// MEMW  | whole pipe frozen on memory busy
module hazard_interlock_unit #(
  parameter int NREG      = 32,
  parameter int CW        = 4,
  parameter int MAX_STALL = 12
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [4:0]      src1_ID,
  input  logic [4:0]      src2_ID,
  input  logic [4:0]      ST_src_ID,
  input  logic            src1_vld_ID,
  input  logic            src2_vld_ID,
  input  logic            ST_vld_ID,
  input  logic [4:0]      dest_ID,
  input  logic            WB_EN_ID,
  input  logic            MEM_R_EN_ID,
  input  logic            ld_done,
  input  logic [4:0]      ld_done_dest,
  input  logic            mem_busy,
  input  logic            br_taken_EXE,
  output logic            stall_IF_ID,
  output logic            bubble_EXE,
  output logic            freeze_pipe,
  output logic            flush_IF_ID,
  output logic            flush_ID_EXE,
  output logic [NREG-1:0] pending_mask,
  output logic [CW-1:0]   stall_cnt,
  output logic            hazard_timeout,
  output logic [31:0]     perf_stall_cycles,
  output logic [31:0]     perf_flush_cnt
);

  typedef enum logic [1:0] {S_RUN, S_HAZ, S_MEMW} hz_state_e;

  localparam logic [CW-1:0] CNT_SAT = '1;
  localparam logic [CW-1:0] CNT_TO  = CW'(MAX_STALL);

  hz_state_e       state, state_nxt;
  logic            rst_q;
  logic            ctrl_en;
  logic [NREG-1:0] clr_vec, set_vec, eff;
  logic            hazard, issue;
  logic [CW-1:0]   cnt_nxt;
  logic            unused_state;

  assign unused_state = ^state;

  always_comb begin
    clr_vec = '0;
    if (ld_done) clr_vec[ld_done_dest] = 1'b1;
    // Same-cycle clear bypass lines up with WB->EXE forwarding.
    eff    = pending_mask & ~clr_vec;
    eff[0] = 1'b0;

    hazard = (src1_vld_ID & eff[src1_ID]) |
             (src2_vld_ID & eff[src2_ID]) |
             (ST_vld_ID   & eff[ST_src_ID]);
    issue  = ~mem_busy & ~br_taken_EXE & ~hazard;

    set_vec = '0;
    if (issue && MEM_R_EN_ID && WB_EN_ID && (dest_ID != 5'd0)) set_vec[dest_ID] = 1'b1;

    if (mem_busy)          state_nxt = S_MEMW;
    else if (br_taken_EXE) state_nxt = S_RUN;
    else if (hazard)       state_nxt = S_HAZ;
    else                   state_nxt = S_RUN;

    cnt_nxt = stall_cnt;
    if (state_nxt == S_HAZ) begin
      if (stall_cnt != CNT_SAT) cnt_nxt = stall_cnt + CW'(1);
    end else if (state_nxt != S_MEMW) begin
      cnt_nxt = '0;
    end
  end

  // Controls stay quiet through reset and the first cycle after it.
  always_comb begin
    ctrl_en      = ~rst & ~rst_q;
    freeze_pipe  = ctrl_en & mem_busy;
    flush_IF_ID  = ctrl_en & ~mem_busy & br_taken_EXE;
    flush_ID_EXE = flush_IF_ID;
    stall_IF_ID  = ctrl_en & ~mem_busy & ~br_taken_EXE & hazard;
    bubble_EXE   = stall_IF_ID;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rst_q          <= 1'b1;
      state          <= S_RUN;
      pending_mask   <= '0;
      stall_cnt      <= '0;
      hazard_timeout <= 1'b0;
    end else begin
      rst_q        <= 1'b0;
      state        <= state_nxt;
      // Set wins over a same-register clear.
      pending_mask <= (pending_mask & ~clr_vec) | set_vec;
      stall_cnt    <= cnt_nxt;
      if (cnt_nxt == CNT_TO) hazard_timeout <= 1'b1;
    end
  end

`ifdef HAZ_PERF_CNT_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      perf_stall_cycles <= '0;
      perf_flush_cnt    <= '0;
    end else begin
      if (stall_IF_ID) perf_stall_cycles <= perf_stall_cycles + 32'd1;
      if (flush_IF_ID) perf_flush_cnt    <= perf_flush_cnt + 32'd1;
    end
  end
`else
  assign perf_stall_cycles = '0;
  assign perf_flush_cnt    = '0;
`endif

endmodule

// File: tb/tb_hazard_interlock_unit.sv
// Directed bench for hazard_interlock_unit: scoreboard, stall, freeze, flush, timeout, reset.
module tb_hazard_interlock_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic [4:0]  src1_ID, src2_ID, ST_src_ID, dest_ID, ld_done_dest;
  logic        src1_vld_ID, src2_vld_ID, ST_vld_ID, WB_EN_ID, MEM_R_EN_ID;
  logic        ld_done, mem_busy, br_taken_EXE;
  logic        stall_IF_ID, bubble_EXE, freeze_pipe, flush_IF_ID, flush_ID_EXE;
  logic [31:0] pending_mask;
  logic [3:0]  stall_cnt;
  logic        hazard_timeout;
  logic [31:0] perf_stall_cycles, perf_flush_cnt;

  int errors = 0;
  int checks = 0;

  hazard_interlock_unit dut (
    .clk(clk), .rst(rst),
    .src1_ID(src1_ID), .src2_ID(src2_ID), .ST_src_ID(ST_src_ID),
    .src1_vld_ID(src1_vld_ID), .src2_vld_ID(src2_vld_ID), .ST_vld_ID(ST_vld_ID),
    .dest_ID(dest_ID), .WB_EN_ID(WB_EN_ID), .MEM_R_EN_ID(MEM_R_EN_ID),
    .ld_done(ld_done), .ld_done_dest(ld_done_dest),
    .mem_busy(mem_busy), .br_taken_EXE(br_taken_EXE),
    .stall_IF_ID(stall_IF_ID), .bubble_EXE(bubble_EXE), .freeze_pipe(freeze_pipe),
    .flush_IF_ID(flush_IF_ID), .flush_ID_EXE(flush_ID_EXE),
    .pending_mask(pending_mask), .stall_cnt(stall_cnt), .hazard_timeout(hazard_timeout),
    .perf_stall_cycles(perf_stall_cycles), .perf_flush_cnt(perf_flush_cnt)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: time limit reached, errors=%0d checks=%0d", errors, checks);
    $fatal(1, "watchdog");
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic idle;
    src1_ID = 0; src2_ID = 0; ST_src_ID = 0; dest_ID = 0; ld_done_dest = 0;
    src1_vld_ID = 0; src2_vld_ID = 0; ST_vld_ID = 0; WB_EN_ID = 0; MEM_R_EN_ID = 0;
    ld_done = 0; mem_busy = 0; br_taken_EXE = 0;
  endtask

  task automatic put_load(input logic [4:0] d);
    MEM_R_EN_ID = 1; WB_EN_ID = 1; dest_ID = d;
  endtask

  task automatic do_reset;
    idle();
    rst = 1;
    tick(); tick();
    rst = 0;
    tick();
  endtask

  // {stall, bubble, freeze, flush_if, flush_ex}
  function automatic logic [4:0] ctl();
    return {stall_IF_ID, bubble_EXE, freeze_pipe, flush_IF_ID, flush_ID_EXE};
  endfunction

  task automatic test_reset;
    logic [4:0] c;
    idle();
    rst = 1; mem_busy = 1; br_taken_EXE = 1;
    tick(); tick();
    c = ctl(); checks++;
    if (c !== 5'b00000) begin errors++; $display("FAIL reset_ctl_during: got %b want 00000", c); end
    rst = 0; #1;
    c = ctl(); checks++;
    if (c !== 5'b00000) begin errors++; $display("FAIL reset_ctl_after: got %b want 00000", c); end
    tick();
    c = ctl(); checks++;
    if (c !== 5'b00100) begin errors++; $display("FAIL reset_freeze_resumes: got %b want 00100", c); end
    idle(); tick();
    checks++;
    if (pending_mask !== 32'h0 || stall_cnt !== 4'd0 || hazard_timeout !== 1'b0) begin
      errors++; $display("FAIL reset_state: mask=%h cnt=%0d to=%b want 0/0/0", pending_mask, stall_cnt, hazard_timeout);
    end
  endtask

  task automatic test_load_use;
    idle(); put_load(5); tick();
    checks++;
    if (pending_mask !== 32'h20) begin errors++; $display("FAIL lu_pending_set: got %h want 00000020", pending_mask); end
    idle(); src1_ID = 5; src1_vld_ID = 1; #1;
    checks++;
    if (ctl() !== 5'b11000) begin errors++; $display("FAIL lu_stall1: got %b want 11000", ctl()); end
    tick();
    checks++;
    if (ctl() !== 5'b11000 || stall_cnt !== 4'd1) begin errors++; $display("FAIL lu_stall2: ctl=%b cnt=%0d want 11000/1", ctl(), stall_cnt); end
    tick();
    checks++;
    if (stall_cnt !== 4'd2) begin errors++; $display("FAIL lu_cnt2: got %0d want 2", stall_cnt); end
    ld_done = 1; ld_done_dest = 5; #1;
    checks++;
    if (ctl() !== 5'b00000) begin errors++; $display("FAIL lu_bypass: got %b want 00000", ctl()); end
    tick(); idle(); #1;
    checks++;
    if (pending_mask !== 32'h0 || stall_cnt !== 4'd0) begin errors++; $display("FAIL lu_cleared: mask=%h cnt=%0d want 0/0", pending_mask, stall_cnt); end
  endtask

  task automatic test_r0;
    idle(); put_load(0); tick();
    idle(); src1_ID = 0; src1_vld_ID = 1; src2_ID = 0; src2_vld_ID = 1; #1;
    checks++;
    if (ctl() !== 5'b00000 || pending_mask !== 32'h0) begin errors++; $display("FAIL r0: ctl=%b mask=%h want 00000/0", ctl(), pending_mask); end
    tick();
  endtask

  task automatic test_store_src;
    idle(); put_load(10); tick();
    idle(); ST_src_ID = 10; ST_vld_ID = 1; #1;
    checks++;
    if (stall_IF_ID !== 1'b1) begin errors++; $display("FAIL st_stall: got %b want 1", stall_IF_ID); end
    ST_vld_ID = 0; src2_ID = 10; #1;
    checks++;
    if (stall_IF_ID !== 1'b0) begin errors++; $display("FAIL st_no_vld: got %b want 0", stall_IF_ID); end
    idle(); ld_done = 1; ld_done_dest = 10; tick(); idle(); #1;
  endtask

  task automatic test_branch_over_stall;
    idle(); put_load(3); tick();
    idle(); src2_ID = 3; src2_vld_ID = 1; put_load(4); br_taken_EXE = 1; #1;
    checks++;
    if (ctl() !== 5'b00011) begin errors++; $display("FAIL br_flush: got %b want 00011", ctl()); end
    tick();
    checks++;
    if (pending_mask !== 32'h8 || stall_cnt !== 4'd0) begin errors++; $display("FAIL br_no_record: mask=%h cnt=%0d want 00000008/0", pending_mask, stall_cnt); end
    br_taken_EXE = 0; #1;
    checks++;
    if (ctl() !== 5'b11000) begin errors++; $display("FAIL stalled_load_ctl: got %b want 11000", ctl()); end
    tick();
    checks++;
    if (pending_mask !== 32'h8) begin errors++; $display("FAIL stalled_load_no_record: got %h want 00000008", pending_mask); end
    idle(); ld_done = 1; ld_done_dest = 3; tick(); idle(); #1;
  endtask

  task automatic test_freeze;
    idle(); put_load(6); tick();
    idle(); src1_ID = 6; src1_vld_ID = 1; tick(); tick();
    put_load(8); mem_busy = 1; br_taken_EXE = 1;
    for (int i = 0; i < 3; i++) begin
      if (i == 2) begin ld_done = 1; ld_done_dest = 6; end
      #1;
      checks++;
      if (ctl() !== 5'b00100) begin errors++; $display("FAIL freeze_cyc%0d: got %b want 00100", i, ctl()); end
      tick();
      checks++;
      if (stall_cnt !== 4'd2) begin errors++; $display("FAIL freeze_cnt_hold%0d: got %0d want 2", i, stall_cnt); end
    end
    checks++;
    if (pending_mask !== 32'h0) begin errors++; $display("FAIL freeze_ld_done: got %h want 0", pending_mask); end
    ld_done = 0; mem_busy = 0; #1;
    checks++;
    if (ctl() !== 5'b00011) begin errors++; $display("FAIL freeze_deferred_flush: got %b want 00011", ctl()); end
    tick();
    checks++;
    if (stall_cnt !== 4'd0 || pending_mask !== 32'h0) begin errors++; $display("FAIL freeze_after: cnt=%0d mask=%h want 0/0", stall_cnt, pending_mask); end
    idle(); tick();
  endtask

  task automatic test_set_clear_race;
    idle(); put_load(7); tick();
    put_load(7); ld_done = 1; ld_done_dest = 7; tick();
    checks++;
    if (pending_mask !== 32'h80) begin errors++; $display("FAIL race_set_wins: got %h want 00000080", pending_mask); end
    idle(); ld_done = 1; ld_done_dest = 7; tick(); idle(); #1;
    checks++;
    if (pending_mask !== 32'h0) begin errors++; $display("FAIL race_clear: got %h want 0", pending_mask); end
  endtask

  task automatic test_timeout;
    idle(); put_load(9); tick();
    idle(); src1_ID = 9; src1_vld_ID = 1;
    repeat (11) tick();
    checks++;
    if (stall_cnt !== 4'd11 || hazard_timeout !== 1'b0) begin errors++; $display("FAIL to_pre: cnt=%0d to=%b want 11/0", stall_cnt, hazard_timeout); end
    tick();
    checks++;
    if (stall_cnt !== 4'd12 || hazard_timeout !== 1'b1) begin errors++; $display("FAIL to_hit: cnt=%0d to=%b want 12/1", stall_cnt, hazard_timeout); end
    repeat (3) tick();
    checks++;
    if (stall_cnt !== 4'd15) begin errors++; $display("FAIL to_cnt15: got %0d want 15", stall_cnt); end
    tick();
    checks++;
    if (stall_cnt !== 4'd15 || hazard_timeout !== 1'b1) begin errors++; $display("FAIL to_sat: cnt=%0d to=%b want 15/1", stall_cnt, hazard_timeout); end
    src1_vld_ID = 0; tick();
    checks++;
    if (stall_cnt !== 4'd0 || hazard_timeout !== 1'b1 || pending_mask !== 32'h200) begin
      errors++; $display("FAIL to_sticky: cnt=%0d to=%b mask=%h want 0/1/00000200", stall_cnt, hazard_timeout, pending_mask);
    end
    src1_vld_ID = 1; tick();
    checks++;
    if (stall_IF_ID !== 1'b1) begin errors++; $display("FAIL to_restall: got %b want 1", stall_IF_ID); end
    rst = 1; tick(); rst = 0; #1;
    checks++;
    if (ctl() !== 5'b00000 || pending_mask !== 32'h0 || stall_cnt !== 4'd0 || hazard_timeout !== 1'b0) begin
      errors++; $display("FAIL midstall_rst: ctl=%b mask=%h cnt=%0d to=%b want all 0", ctl(), pending_mask, stall_cnt, hazard_timeout);
    end
    tick();
    checks++;
    if (stall_IF_ID !== 1'b0 || stall_cnt !== 4'd0) begin errors++; $display("FAIL midstall_resume: stall=%b cnt=%0d want 0/0", stall_IF_ID, stall_cnt); end
    idle();
  endtask

  task automatic test_perf;
    logic [31:0] exp_s, exp_f;
`ifdef HAZ_PERF_CNT_EN
    exp_s = 32'd3; exp_f = 32'd2;
`else
    exp_s = 32'd0; exp_f = 32'd0;
`endif
    do_reset();
    checks++;
    if (perf_stall_cycles !== 32'd0 || perf_flush_cnt !== 32'd0) begin
      errors++; $display("FAIL perf_reset: stall=%0d flush=%0d want 0/0", perf_stall_cycles, perf_flush_cnt);
    end
    put_load(11); tick();
    idle(); src1_ID = 11; src1_vld_ID = 1; repeat (3) tick();
    ld_done = 1; ld_done_dest = 11; tick();
    idle(); br_taken_EXE = 1; repeat (2) tick();
    idle(); tick();
    checks++;
    if (perf_stall_cycles !== exp_s || perf_flush_cnt !== exp_f) begin
      errors++; $display("FAIL perf_counts: stall=%0d flush=%0d want %0d/%0d", perf_stall_cycles, perf_flush_cnt, exp_s, exp_f);
    end
  endtask

  initial begin
    idle();
    rst = 1;
    test_reset();
    test_load_use();
    test_r0();
    test_store_src();
    test_branch_over_stall();
    test_freeze();
    test_set_clear_race();
    test_timeout();
    test_perf();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
